// File: rtl/blake2_msg_packer.sv
// rtl/blake2_msg_packer.sv - packs a W-bit word stream into 16-word BLAKE2 blocks with byte count t and final flag f
// Optional: define BLAKE2_PACK_ERR_EN to add the sticky err_o protocol-error flag.
module blake2_msg_packer #(
    parameter int W  = 64,
    parameter int BW = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            data_valid_i,
    output logic            data_ready_o,
    input  logic [W-1:0]    data_i,
    input  logic            data_last_i,
    input  logic [BW-1:0]   data_bytes_i,
    output logic            blk_valid_o,
    input  logic            blk_ready_i,
    output logic [16*W-1:0] blk_o,
    output logic [2*W-1:0]  t_o,
    output logic            f_o
`ifdef BLAKE2_PACK_ERR_EN
    ,
    output logic            err_o
`endif
);

    localparam int NB = W / 8;
    localparam int CW = 2 * W;
    localparam logic [BW-1:0] FULL_BYTES = BW'(NB);

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [16*W-1:0] buf_q, buf_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   t_q, t_d;
    logic            f_q, f_d;

    logic            accept;
    logic [BW-1:0]   bytes_eff;
    logic [W-1:0]    word_masked;

    assign accept = data_valid_i && (state_q == FILL);

`ifdef BLAKE2_PACK_ERR_EN
    logic bad_word;
    logic err_q, err_d;

    // Malformed words are packed as full words so the block layout stays sane.
    always_comb begin
        bad_word  = (!data_last_i && (data_bytes_i != FULL_BYTES))
                 || (data_bytes_i > FULL_BYTES)
                 || ((data_bytes_i == '0) && (idx_q != 4'd0));
        bytes_eff = bad_word ? FULL_BYTES : data_bytes_i;
        err_d     = err_q || (accept && bad_word);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign bytes_eff = data_bytes_i;
`endif

    // Bytes beyond the valid count are forced to zero so padding is implicit.
    always_comb begin
        word_masked = '0;
        for (int j = 0; j < NB; j++) begin
            if (BW'(j) < bytes_eff) begin
                word_masked[8*j +: 8] = data_i[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        f_d     = f_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(bytes_eff);
                    for (int k = 0; k < 16; k++) begin
                        if (4'(k) == idx_q) begin
                            buf_d[k*W +: W] = word_masked;
                        end else if (data_last_i && (4'(k) > idx_q)) begin
                            buf_d[k*W +: W] = '0;
                        end
                    end
                    if (data_last_i) begin
                        state_d = SEND;
                        t_d     = cnt_d;
                        f_d     = 1'b1;
                    end else if (idx_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                // A pending word proves this full block is not the final one.
                if (data_valid_i) begin
                    state_d = SEND;
                    t_d     = cnt_q;
                    f_d     = 1'b0;
                end
            end
            SEND: begin
                if (blk_ready_i) begin
                    state_d = FILL;
                    buf_d   = '0;
                    idx_d   = '0;
                    if (f_q) begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= FILL;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            f_q     <= f_d;
        end
    end

    assign data_ready_o = (state_q == FILL);
    assign blk_valid_o  = (state_q == SEND);
    assign blk_o        = buf_q;
    assign t_o          = t_q;
    assign f_o          = f_q;

endmodule

// File: tb/tb_blake2_msg_packer.sv
// tb/tb_blake2_msg_packer.sv - self-checking bench for blake2_msg_packer (W=64)
module tb_blake2_msg_packer;

    localparam int W  = 64;
    localparam int BW = 4;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            nreset;
    logic            data_valid_i;
    logic            data_ready_o;
    logic [W-1:0]    data_i;
    logic            data_last_i;
    logic [BW-1:0]   data_bytes_i;
    logic            blk_valid_o;
    logic            blk_ready_i;
    logic [16*W-1:0] blk_o;
    logic [2*W-1:0]  t_o;
    logic            f_o;

    blake2_msg_packer #(.W(W), .BW(BW)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_i       (data_i),
        .data_last_i  (data_last_i),
        .data_bytes_i (data_bytes_i),
        .blk_valid_o  (blk_valid_o),
        .blk_ready_i  (blk_ready_i),
        .blk_o        (blk_o),
        .t_o          (t_o),
        .f_o          (f_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [BW-1:0] bytes;
        logic          last;
    } word_t;

    typedef struct packed {
        logic [16*W-1:0] blk;
        logic [2*W-1:0]  t;
        logic            f;
    } blk_t;

    typedef struct {
        int len;
        int nblk;
        int t_first;
        bit f_first;
        int t_last;
    } vec_t;

    word_t wq[$];
    blk_t  eq[$];
    blk_t  gq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [16*W-1:0] act, input logic [16*W-1:0] exp);
        bit shown = 1'b0;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int k = 0; k < 16; k++) begin
                if (!shown && (act[k*W +: W] !== exp[k*W +: W])) begin
                    $display("FAIL %s word%0d actual=%h required=%h", name, k, act[k*W +: W], exp[k*W +: W]);
                    shown = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input int b, input bit l);
        data_valid_i = v;
        data_i       = d;
        data_bytes_i = BW'(b);
        data_last_i  = l;
    endtask

    task automatic do_reset();
        nreset       = 1'b0;
        blk_ready_i  = 1'b0;
        drive(1'b0, '0, 0, 1'b0);
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_blk_valid"}, blk_valid_o, 1'b0);
        chk1({tag, "_f"}, f_o, 1'b0);
        chkw({tag, "_t"}, t_o, 128'd0);
        chk_blk({tag, "_blk"}, blk_o, '0);
        chk1({tag, "_ready"}, data_ready_o, 1'b1);
    endtask

    // Reference: message bytes split into 8-byte words and 128-byte zero-padded blocks.
    task automatic add_msg(input int len, input bit rnd);
        logic [7:0] m[$];
        word_t      w;
        blk_t       e;
        int         nblk;
        int         nb;
        for (int i = 0; i < len; i++) m.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        if (len == 0) begin
            w.data  = {$urandom, $urandom};
            w.bytes = '0;
            w.last  = 1'b1;
            wq.push_back(w);
        end else begin
            for (int s = 0; s < len; s += NB) begin
                nb      = (len - s < NB) ? len - s : NB;
                w.data  = {$urandom, $urandom};
                for (int j = 0; j < nb; j++) w.data[8*j +: 8] = m[s+j];
                w.bytes = BW'(nb);
                w.last  = (s + NB >= len);
                wq.push_back(w);
            end
        end
        nblk = (len == 0) ? 1 : (len + 127) / 128;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int i = 0; i < 128 && b * 128 + i < len; i++) e.blk[8*i +: 8] = m[b*128+i];
            e.t = (b == nblk - 1) ? 128'(len) : 128'((b + 1) * 128);
            e.f = (b == nblk - 1);
            eq.push_back(e);
        end
    endtask

    task automatic run(input int valid_pct, input int ready_pct, input int n_exp, input int budget);
        int   cyc = 0;
        blk_t g;
        while ((wq.size() > 0 || gq.size() < n_exp) && cyc < budget) begin
            @(negedge clk);
            if (wq.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                drive(1'b1, wq[0].data, int'(wq[0].bytes), wq[0].last);
            end else begin
                drive(1'b0, {$urandom, $urandom}, 0, 1'b0);
            end
            blk_ready_i = (int'($urandom_range(99)) < ready_pct);
            #1;
            if (data_valid_i && data_ready_o) void'(wq.pop_front());
            if (blk_valid_o && blk_ready_i) begin
                g.blk = blk_o;
                g.t   = t_o;
                g.f   = f_o;
                gq.push_back(g);
            end
            cyc++;
        end
        @(negedge clk);
        data_valid_i = 1'b0;
        blk_ready_i  = 1'b0;
        if (cyc >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout cycles=%0d limit=%0d pending_words=%0d", cyc, budget, wq.size());
        end
    endtask

    task automatic compare_blocks(input string tag);
        chkw({tag, "_nblocks"}, 128'(gq.size()), 128'(eq.size()));
        for (int i = 0; i < gq.size() && i < eq.size(); i++) begin
            chk_blk($sformatf("%s_b%0d_blk", tag, i), gq[i].blk, eq[i].blk);
            chkw($sformatf("%s_b%0d_t", tag, i), gq[i].t, eq[i].t);
            chk1($sformatf("%s_b%0d_f", tag, i), gq[i].f, eq[i].f);
        end
    endtask

    initial begin
        vec_t            tbl[8];
        logic [16*W-1:0] exp_blk;
        logic [16*W-1:0] held_blk;
        logic [2*W-1:0]  held_t;
        logic            held_f;
        bit              ok;
        int              specials[5];
        int              len;

        tbl[0] = '{0,   1, 0,   1, 0};
        tbl[1] = '{3,   1, 3,   1, 3};
        tbl[2] = '{8,   1, 8,   1, 8};
        tbl[3] = '{127, 1, 127, 1, 127};
        tbl[4] = '{128, 1, 128, 1, 128};
        tbl[5] = '{129, 2, 128, 0, 129};
        tbl[6] = '{256, 2, 128, 0, 256};
        tbl[7] = '{300, 3, 128, 0, 300};
        specials = '{0, 127, 128, 129, 256};

        do_reset();
        check_reset_state("reset");

        // Empty message: all-zero block one cycle after acceptance.
        drive(1'b1, 64'hfeed_face_cafe_beef, 0, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1'b0);
        chk1("empty_latency", blk_valid_o, 1'b1);
        chk_blk("empty_blk", blk_o, '0);
        chkw("empty_t", t_o, 128'd0);
        chk1("empty_f", f_o, 1'b1);
        chk1("empty_ready_low", data_ready_o, 1'b0);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk1("empty_done_valid", blk_valid_o, 1'b0);
        chk1("empty_done_ready", data_ready_o, 1'b1);

        // "abc" with garbage in the unused upper bytes.
        drive(1'b1, 64'hdead_beef_ff63_6261, 3, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1'b0);
        exp_blk = '0;
        exp_blk[23:0] = 24'h636261;
        chk_blk("abc_blk", blk_o, exp_blk);
        chkw("abc_t", t_o, 128'd3);
        chk1("abc_f", f_o, 1'b1);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;

        // Exactly 128 bytes: ready never drops before SEND.
        for (int i = 0; i < 128; i++) exp_blk[8*i +: 8] = 8'(i * 3 + 1);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ok &= data_ready_o;
            drive(1'b1, exp_blk[k*W +: W], 8, k == 15);
            tick();
        end
        drive(1'b0, '0, 0, 1'b0);
        chk1("b128_ready_high", ok, 1'b1);
        chk1("b128_valid", blk_valid_o, 1'b1);
        chk_blk("b128_blk", blk_o, exp_blk);
        chkw("b128_t", t_o, 128'd128);
        chk1("b128_f", f_o, 1'b1);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk1("b128_no_trailer", blk_valid_o, 1'b0);

        // 129 bytes: HOLD waits idle, then backpressure on the first block.
        for (int k = 0; k < 16; k++) begin
            exp_blk[k*W +: W] = {$urandom, $urandom};
            drive(1'b1, exp_blk[k*W +: W], 8, 1'b0);
            tick();
        end
        drive(1'b0, '0, 0, 1'b0);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            ok &= !blk_valid_o && !data_ready_o;
        end
        chk1("b129_hold_idle", ok, 1'b1);
        drive(1'b1, 64'h1234_5678_9abc_de5a, 1, 1'b1);
        tick();
        chk1("b129_hold_latency", blk_valid_o, 1'b1);
        chk_blk("b129_first_blk", blk_o, exp_blk);
        chkw("b129_first_t", t_o, 128'd128);
        chk1("b129_first_f", f_o, 1'b0);
        held_blk = blk_o;
        held_t   = t_o;
        held_f   = f_o;
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            ok &= blk_valid_o && !data_ready_o && (blk_o === held_blk) && (t_o === held_t) && (f_o === held_f);
        end
        chk1("backpressure_stable", ok, 1'b1);
        blk_ready_i = 1'b1;
        tick();
        blk_ready_i = 1'b0;
        chk1("b129_fill_valid", blk_valid_o, 1'b0);
        chk1("b129_fill_ready", data_ready_o, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1'b0);
        exp_blk = '0;
        exp_blk[7:0] = 8'h5a;
        chk1("b129_second_valid", blk_valid_o, 1'b1);
        chk_blk("b129_second_blk", blk_o, exp_blk);
        chkw("b129_second_t", t_o, 128'd129);
        chk1("b129_second_f", f_o, 1'b1);
        blk_ready_i = 1'b1;
        tick();

        // Reset after 7 words; stray blk_ready_i stays high throughout.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, {$urandom, $urandom}, 8, 1'b0);
            tick();
        end
        drive(1'b0, '0, 0, 1'b0);
        chk1("ready_ignored_in_fill", blk_valid_o, 1'b0);
        nreset = 1'b0;
        tick();
        check_reset_state("midreset");
        nreset = 1'b1;
        drive(1'b1, 64'h0000_0000_0063_6261, 3, 1'b1);
        tick();
        drive(1'b0, '0, 0, 1'b0);
        exp_blk = '0;
        exp_blk[23:0] = 24'h636261;
        chkw("midreset_abc_t", t_o, 128'd3);
        chk_blk("midreset_abc_blk", blk_o, exp_blk);
        tick();
        blk_ready_i = 1'b0;

        // Table-driven single messages with full-rate handshakes.
        for (int i = 0; i < 8; i++) begin
            wq.delete();
            eq.delete();
            gq.delete();
            add_msg(tbl[i].len, 1'b0);
            run(100, 100, eq.size(), 2000);
            chkw($sformatf("tbl%0d_nblk", i), 128'(gq.size()), 128'(tbl[i].nblk));
            if (gq.size() > 0) begin
                chkw($sformatf("tbl%0d_t_first", i), gq[0].t, 128'(tbl[i].t_first));
                chk1($sformatf("tbl%0d_f_first", i), gq[0].f, tbl[i].f_first);
                chkw($sformatf("tbl%0d_t_last", i), gq[gq.size()-1].t, 128'(tbl[i].t_last));
            end
            compare_blocks($sformatf("tbl%0d", i));
        end

        // Randomized back-to-back messages with random valid/ready gaps.
        wq.delete();
        eq.delete();
        gq.delete();
        for (int m = 0; m < 30; m++) begin
            len = (m < 5) ? specials[m] : int'($urandom_range(300));
            add_msg(len, 1'b1);
        end
        run(60, 60, eq.size(), 20000);
        compare_blocks("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/blake2_msg_packer.md
Name: blake2_msg_packer

Overview:
- Feeds the BLAKE2 compression core. Accepts the message as a stream of W-bit words with a valid/ready handshake and packs them into 16-word blocks.
- Zero-pads the final partial block and tracks the byte offset counter t.
- Decides the final-block flag f and presents {block, t, f} to the core over a valid/ready handshake.
- A full block is held back until the packer knows whether it is the last one.

Parameters:
- W, 64, word width in bits (64 = BLAKE2b, 32 = BLAKE2s); block is 16*W bits.
- BW, 4, width of the byte-count field, log2(W/8)+1 (4 for W=64, 3 for W=32).

Ports:
- clk  input  1  clock.
- nreset  input  1  synchronous active-low reset.
- data_valid_i  input  1  input word valid.
- data_ready_o  output  1  packer accepts a word this cycle.
- data_i  input  W  message word, little-endian: byte j at bits [8j+7:8j].
- data_last_i  input  1  word is the last of the message.
- data_bytes_i  input  BW  valid bytes in the word, 0..W/8. Must equal W/8 when data_last_i=0. The value 0 is legal only on a last word that is the first word of a block (empty-message marker).
- blk_valid_o  output  1  block available.
- blk_ready_i  input  1  core accepts the block.
- blk_o  output  16*W  word k at bits [k*W+W-1:k*W], same layout as the core's d_i.
- t_o  output  2*W  total message bytes up to and including this block.
- f_o  output  1  final-block flag.

Behaviour:
- States: FILL, HOLD, SEND. State is reset to FILL.
- Reset values: blk_valid_o=0, f_o=0, t_o=0, blk_o=0, data_ready_o=1. Word index idx=0, byte counter cnt=0.
- Reset mid-operation discards the buffered block and the counter. No block is emitted.
- data_ready_o=1 only in FILL. A word is accepted when data_valid_i & data_ready_o.
- FILL, word accepted:
  - Write data_i to buffer word idx. Bytes at positions >= data_bytes_i are written as 0.
  - cnt += data_bytes_i, modulo 2^(2W).
  - data_last_i=1: clear all words above idx, go to SEND with f=1.
  - data_last_i=0, idx=15: go to HOLD.
  - Otherwise: idx++.
- HOLD: data_ready_o=0. The packer inspects data_valid_i without consuming the word.
  - data_valid_i=1: next cycle go to SEND with f=0. Because non-last words are full, t=cnt and is a multiple of 128 (W=64).
  - data_valid_i=0: wait indefinitely.
- SEND:
  - blk_valid_o=1. blk_o, t_o and f_o are registered and stable until the handshake completes.
  - On blk_ready_i=1: blk_valid_o drops next cycle, buffer and idx clear, state returns to FILL.
  - If f=1, cnt also clears, ready for the next message.
  - blk_ready_i=0 holds SEND indefinitely.
- Latency:
  - Last word accepted in cycle n → blk_valid_o=1 in cycle n+1.
  - HOLD with data_valid_i=1 in cycle n → blk_valid_o=1 in cycle n+1.
  - Minimum one idle cycle on data_ready_o between blocks (the SEND cycle).
- Exactly-128-byte boundary: a last word at idx=15 goes directly to SEND f=1. HOLD is never entered and no trailing empty block is produced.
- Empty message: a last word with data_bytes_i=0 at idx=0 gives an all-zero block, t=0, f=1.
- Counter wrap: cnt wraps modulo 2^(2W) silently.
- blk_ready_i asserted while blk_valid_o=0 is ignored.

Optional Feature:
- Macro BLAKE2_PACK_ERR_EN adds output err_o (1 bit, reset 0), a sticky protocol-error flag. It is set on an accepted word with any of:
  - data_last_i=0 and data_bytes_i!=W/8;
  - data_bytes_i>W/8;
  - data_bytes_i=0 and idx!=0.
- err_o is cleared only by reset.
- With the macro defined, an erroneous word is still packed as if data_bytes_i were clamped to W/8.
- Without the macro: no err_o port, no checking logic, and such input is undefined behaviour.

Test Plan:
- Empty message: data_last_i=1, data_bytes_i=0 → one block, blk_o=0, t_o=0, f_o=1 → blk_valid_o=1 one cycle after acceptance.
- "abc": data_i=0x636261, bytes=3, last=1 → word0=0x0000000000636261, words1..15=0, t_o=3, f_o=1.
- 128 bytes: 16 full words, last on 16th → single block with f_o=1, t_o=128. HOLD never visited; data_ready_o drops only in SEND.
- 129 bytes: 16 full words, then idle 10 cycles → blk_valid_o stays 0 and data_ready_o=0. A 17th word arrives (bytes=1, last) → block f_o=0, t_o=128. After the handshake the 17th word is accepted → second block with word0 byte0 only, t_o=129, f_o=1.
- Backpressure: blk_ready_i=0 for 5 cycles in SEND → blk_o, t_o, f_o stable, data_ready_o=0. blk_ready_i=1 → FILL next cycle.
- Reset mid-operation: nreset=0 after 7 words accepted → outputs at reset values. A following "abc" message yields t_o=3, not 59.
